score_reader: RTL

Command source for the music sequencer: fetches 12-bit command words from an external synchronous score ROM and drives them onto the sequencer's `command` input. It paces itself on the sequencer's `busy` output, so each delay completes before the next word is issued. It sits between the score ROM and the sequencer in the music top level, and produces the stream the sequencer consumes.

---
 rtl/score_reader_pkg.sv | 21 ++
 rtl/score_reader.sv | 95 +++++++++
 2 files changed

// File: rtl/score_reader_pkg.sv
// Constants and FSM state type shared by the score reader and the music sequencer.
// Command word: bit 11 = delay flag, else bit 10 selects note start vs note stop.
package score_reader_pkg;

  localparam int CMD_W         = 12;
  localparam int CMD_DELAY_BIT = 11;
  localparam int CMD_START_BIT = 10;

  localparam logic [CMD_W-1:0] CMD_END     = 12'h800;
  localparam logic [CMD_W-1:0] CMD_SILENCE = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ARM,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/score_reader.sv
// Score reader: fetches command words from a synchronous score ROM and paces them on sequencer busy.
// Define SCORE_LOOP_EN to restart the score at address 0 on the end marker instead of stopping.
module score_reader
  import score_reader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              busy,
  input  logic [CMD_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [CMD_W-1:0]  command,
  output logic              playing,
  output logic              done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CMD_W-1:0]  command_nxt;
  logic [CMD_W-1:0]  last_note, last_note_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      command   <= CMD_SILENCE;
      last_note <= CMD_SILENCE;
    end else begin
      state     <= state_nxt;
      rom_addr  <= addr_nxt;
      command   <= command_nxt;
      last_note <= last_note_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = rom_addr;
    command_nxt   = command;
    last_note_nxt = last_note;

    case (state)
      ST_IDLE, ST_DONE: begin
        command_nxt = CMD_SILENCE;
        if (start) begin
          addr_nxt  = '0;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (rom_data == CMD_END) begin
`ifdef SCORE_LOOP_EN
          addr_nxt    = '0;
          state_nxt   = ST_FETCH;
`else
          command_nxt = CMD_SILENCE;
          state_nxt   = ST_DONE;
`endif
        end else if (rom_data[CMD_DELAY_BIT]) begin
          command_nxt = rom_data;
          addr_nxt    = rom_addr + ADDR_W'(1);
          state_nxt   = ST_ARM;
        end else begin
          command_nxt   = rom_data;
          last_note_nxt = rom_data;
          addr_nxt      = rom_addr + ADDR_W'(1);
          state_nxt     = ST_FETCH;
        end
      end
      // Sequencer needs a cycle to see the delay flag before busy is meaningful.
      ST_ARM: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!busy) begin
          // Dropping bit 11 here gives the next delay a fresh rising edge.
          command_nxt = last_note;
          state_nxt   = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (abort) begin
      state_nxt   = ST_IDLE;
      command_nxt = CMD_SILENCE;
    end
  end

  assign playing = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);

endmodule
